spi_line_sync: RTL and testbench

Parametrised multi-channel input conditioner for asynchronous serial-interface lines such as SCK, CS and MOSI. Each channel passes through a configurable-depth synchroniser, then a consecutive-sample glitch filter. The block outputs the filtered level plus one-cycle rise and fall strobes. It sits between the pads and the serial receiver, and generalises the fixed 2-line, 3-flop edge detector used there today.

---
 rtl/spi_line_sync.sv | 111 +++++++++++
 tb/tb_spi_line_sync.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_line_sync.sv
// spi_line_sync: per-channel synchroniser + consecutive-sample glitch filter with rise/fall strobes.
// Define SPI_LINE_SYNC_EDGE_CNT_EN to build the per-channel rise counters (edge_cnt / cnt_clr).
module spi_line_sync_ch #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_LEN    = 2,
   parameter logic RST_BIT     = 1'b0,
   parameter int   CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             cnt_clr,
   output logic             dout,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_cnt
);
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FW-1:0] CNT_MAX = FW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [FW-1:0]          cnt;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= {SYNC_STAGES{RST_BIT}};
      else        sync <= {sync[SYNC_STAGES-2:0], din};
   end

   // Any sample agreeing with dout restarts the run; a commit also restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= RST_BIT;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            dout <= s;
            cnt  <= '0;
            rise <= s;
            fall <= ~s;
         end else begin
            cnt <= cnt + FW'(1);
         end
      end
   end

`ifdef SPI_LINE_SYNC_EDGE_CNT_EN
   // Counts visible rise strobes; clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       edge_cnt <= '0;
      else if (cnt_clr) edge_cnt <= '0;
      else if (rise)    edge_cnt <= edge_cnt + CNT_W'(1);
   end
`else
   logic unused_clr;
   assign unused_clr = cnt_clr;
   assign edge_cnt   = '0;
`endif
endmodule

module spi_line_sync #(
   parameter int             NCH         = 3,
   parameter int             SYNC_STAGES = 2,
   parameter int             FILT_LEN    = 2,
   parameter logic [NCH-1:0] RST_VAL     = '0,
   parameter int             CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       din,
   output logic [NCH-1:0]       dout,
   output logic [NCH-1:0]       rise,
   output logic [NCH-1:0]       fall,
   input  logic                 cnt_clr,
   output logic [NCH*CNT_W-1:0] edge_cnt
);
   generate
      if (NCH < 1)         begin : g_bad_nch  $error("spi_line_sync: NCH must be >= 1");         end
      if (SYNC_STAGES < 2) begin : g_bad_ss   $error("spi_line_sync: SYNC_STAGES must be >= 2"); end
      if (FILT_LEN < 1)    begin : g_bad_fl   $error("spi_line_sync: FILT_LEN must be >= 1");    end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < NCH; i++) begin : g_ch
         spi_line_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .RST_BIT     (RST_VAL[i]),
            .CNT_W       (CNT_W)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (din[i]),
            .cnt_clr  (cnt_clr),
            .dout     (dout[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .edge_cnt (edge_cnt[i*CNT_W +: CNT_W])
         );
      end
   endgenerate
endmodule

// File: tb/tb_spi_line_sync.sv
// Randomised scoreboard bench for spi_line_sync; reference model works on per-edge sample histories.
module tb_spi_line_sync;
   localparam int             NCH   = 3;
   localparam int             SS    = 2;
   localparam int             FL    = 3;
   localparam logic [NCH-1:0] RST   = 3'b100;
   localparam int             CNT_W = 2;
   localparam int             MAXC  = 256;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH-1:0]       din;
   logic [NCH-1:0]       dout, rise, fall;
   logic                 cnt_clr;
   logic [NCH*CNT_W-1:0] edge_cnt;

   spi_line_sync #(.NCH(NCH), .SYNC_STAGES(SS), .FILT_LEN(FL), .RST_VAL(RST), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .rise(rise), .fall(fall),
      .cnt_clr(cnt_clr), .edge_cnt(edge_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0]       d;
      logic [NCH-1:0]       r;
      logic [NCH-1:0]       f;
      logic [NCH*CNT_W-1:0] e;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0;

   // History arrays indexed by edge number since reset release (index 0 = reset state).
   logic [NCH-1:0] dv [0:MAXC];
   logic [NCH-1:0] sh [0:MAXC];
   logic [NCH-1:0] lv [0:MAXC];
   logic [NCH-1:0] rv [0:MAXC];
   logic [NCH-1:0] fv [0:MAXC];
   int             lastc [NCH];
   int unsigned    ecm [NCH];
   int             hold [NCH];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      lv[0] = RST; sh[0] = RST; rv[0] = '0; fv[0] = '0; dv[0] = RST;
      for (int i = 0; i < NCH; i++) begin lastc[i] = 0; ecm[i] = 0; end
   endtask

   // dout flips at edge n when the FL synchronised samples seen before edge n all disagree
   // with the level and no level change happened inside that window.
   task automatic model_step(input int n, input logic [NCH-1:0] d, input logic clr);
      exp_t e;
      dv[n] = d;
      sh[n] = (n - SS + 1 >= 1) ? dv[n-SS+1] : RST;
      lv[n] = lv[n-1]; rv[n] = '0; fv[n] = '0;
      for (int i = 0; i < NCH; i++) begin
         if (n - FL >= lastc[i]) begin
            bit all_diff = 1'b1;
            for (int k = 1; k <= FL; k++)
               if (sh[n-k][i] == lv[n-1][i]) all_diff = 1'b0;
            if (all_diff) begin
               lv[n][i] = ~lv[n-1][i];
               rv[n][i] = lv[n][i];
               fv[n][i] = ~lv[n][i];
               lastc[i] = n;
            end
         end
`ifdef SPI_LINE_SYNC_EDGE_CNT_EN
         if (clr)              ecm[i] = 0;
         else if (rv[n-1][i])  ecm[i] = (ecm[i] + 1) % (1 << CNT_W);
`endif
      end
      e.d = lv[n]; e.r = rv[n]; e.f = fv[n]; e.e = '0;
      for (int i = 0; i < NCH; i++) e.e[i*CNT_W +: CNT_W] = CNT_W'(ecm[i]);
      if (clr) e.e = e.e;
      q.push_back(e);
      n_push++;
   endtask

   // Monitor: one expectation per clock edge while the DUT is running.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_pop++;
            chk("dout",     32'(dout),     32'(e.d));
            chk("rise",     32'(rise),     32'(e.r));
            chk("fall",     32'(fall),     32'(e.f));
            chk("edge_cnt", 32'(edge_cnt), 32'(e.e));
            if ((rise & fall) != '0) chk("rise_fall_excl", 32'(rise & fall), 32'd0);
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_dout"}, 32'(dout),     32'(RST));
      chk({tag, "_rise"}, 32'(rise),     32'd0);
      chk({tag, "_fall"}, 32'(fall),     32'd0);
      chk({tag, "_ecnt"}, 32'(edge_cnt), 32'd0);
   endtask

   initial begin
      int ncyc;
      rst_n = 1'b0; din = RST; cnt_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("rst_hold");
      din = 3'b101;            // raise din[0] while held in reset
      cnt_clr = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("rst_din");
      cnt_clr = 1'b0;

      for (int ph = 0; ph < 8; ph++) begin
         model_reset();
         din = NCH'($urandom);  // may differ from RST at release
         for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(1, 6);
         rst_n = 1'b1;
         ncyc = 40 + int'($urandom_range(0, 60));
         for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
               for (int i = 0; i < NCH; i++) begin
                  if (hold[i] == 0) begin din[i] = ~din[i]; hold[i] = $urandom_range(1, 6); end
                  else hold[i]--;
               end
               if ($urandom_range(0, 15) == 0) begin
                  din = ~din;
                  for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(3, 6);
               end
            end
            cnt_clr = ($urandom_range(0, 9) == 0);
            model_step(c, din, cnt_clr);
            @(negedge clk);
         end
         @(posedge clk);
         #2;
         rst_n = 1'b0;           // asynchronous, mid-cycle, at an arbitrary filter state
         #1;
         chk_reset("rst_async");
         din = NCH'($urandom);
         repeat (2) @(negedge clk);
         chk_reset("rst_mid");
      end

      chk("queue_drain", 32'(q.size()), 32'd0);
      chk("pop_count",   32'(n_pop),    32'(n_push));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
